logic_unit_arbiter: RTL and testbench

Shares a single registered bitwise logic unit between NREQ requesters using round-robin arbitration. Each requester submits an opcode and two WIDTH-bit operands over a valid/ready handshake. The arbiter executes one operation at a time and returns the result, tagged with the requester ID, over a valid/ready response channel. It sits in front of the logic-gate datapath and sequences access to it.

---
 rtl/logic_unit_arbiter_if.sv | 34 +++
 rtl/logic_unit_arbiter.sv | 151 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter_if
// Request/response bundle between NREQ requesters and the shared logic unit.
// Rev 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  // Requester / consumer side
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// logic_unit_arbiter
// Round-robin arbiter sharing one registered bitwise logic unit between NREQ
// requesters; returns each result tagged with the owning requester index.
// Rev 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  logic_unit_arbiter_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              grant;
  logic              grant_found;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   req_ready_c;

  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [2:0]        id_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic [2:0]        rsp_id_q;
  logic              busy_q;

  logic [2:0]        op_arr [NREQ];
  logic [WIDTH-1:0]  a_arr  [NREQ];
  logic [WIDTH-1:0]  b_arr  [NREQ];

  // Split the packed per-requester payload buses into indexable arrays
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign op_arr[k] = bus.req_op[3*k +: 3];
    assign a_arr[k]  = bus.req_a[WIDTH*k +: WIDTH];
    assign b_arr[k]  = bus.req_b[WIDTH*k +: WIDTH];
  end

  function automatic logic [WIDTH-1:0] logic_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (op)
      3'd0:    return ~a;
      3'd1:    return ~b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a grant is only possible while IDLE
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: if (grant_found) begin
              grant      = 1'b1;
              state_next = EXEC;
            end
      EXEC: state_next = RESP;
      RESP: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-hot ready to the winner only
  always_comb begin
    req_ready_c = '0;
    if (grant) req_ready_c[grant_idx] = 1'b1;
  end

  // Capture the winner's payload and advance the priority pointer past it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else if (grant) begin
      ptr  <= PW'((int'(grant_idx) + 1) % NREQ);
      op_q <= op_arr[grant_idx];
      a_q  <= a_arr[grant_idx];
      b_q  <= b_arr[grant_idx];
      id_q <= 3'(grant_idx);
    end
  end

  // Execute in EXEC; result and tag then hold untouched through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (state == EXEC) begin
      rsp_data_q <= logic_fn(op_q, a_q, b_q);
      rsp_id_q   <= id_q;
    end
  end

  // busy is registered from the next state so it is high exactly in EXEC/RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (state_next != IDLE);
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// tb_logic_unit_arbiter
// Directed vector bench for the round-robin logic-unit arbiter.
// Rev 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Per-requester payload, packed onto the interface buses
  logic [2:0] op_t [NREQ];
  logic [3:0] a_t  [NREQ];
  logic [3:0] b_t  [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_pack
    assign bus.req_op[3*k +: 3] = op_t[k];
    assign bus.req_a[4*k +: 4]  = a_t[k];
    assign bus.req_b[4*k +: 4]  = b_t[k];
  end

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    int         rid;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return ~b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle with inputs just driven.
  // Checks grant, EXEC cycle, RESP cycle (grant+2), then accepts.
  task automatic do_txn(input int exp_id, input logic [3:0] exp_data, input bit drop);
    #1;
    check("idle_busy", 32'(bus.busy), 0);
    check("grant", 32'(bus.req_ready), 1 << exp_id);
    tick();
    if (drop) bus.req_valid = bus.req_valid & ~4'(1 << exp_id);
    #1;
    check("exec_ready", 32'(bus.req_ready), 0);
    check("exec_busy", 32'(bus.busy), 1);
    check("exec_rsp_valid", 32'(bus.rsp_valid), 0);
    tick();
    #1;
    check("resp_valid", 32'(bus.rsp_valid), 1);
    check("resp_id", 32'(bus.rsp_id), 32'(exp_id));
    check("resp_data", 32'(bus.rsp_data), 32'(exp_data));
    check("resp_ready", 32'(bus.req_ready), 0);
    tick();
  endtask

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vec_count);
    $fatal(1, "timeout");
  end

  initial begin
    int         mstate;
    int         mptr;
    int         g;
    int         idx;
    logic [3:0] v;
    logic [3:0] expr;

    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      op_t[k] = 3'(k + 2);
      a_t[k]  = 4'(k * 3 + 1);
      b_t[k]  = 4'hA;
    end

    // Reset values, checked while reset is asserted
    #2;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst = 1'b0;

    // Opcode sweep on requester 0 plus single-requester vectors on 1..3
    vecs[0]  = '{0, 3'd0, 4'h3, 4'h5, 4'hC};
    vecs[1]  = '{0, 3'd1, 4'h3, 4'h5, 4'hA};
    vecs[2]  = '{0, 3'd2, 4'h3, 4'h5, 4'h1};
    vecs[3]  = '{0, 3'd3, 4'h3, 4'h5, 4'h7};
    vecs[4]  = '{0, 3'd4, 4'h3, 4'h5, 4'hE};
    vecs[5]  = '{0, 3'd5, 4'h3, 4'h5, 4'h8};
    vecs[6]  = '{0, 3'd6, 4'h3, 4'h5, 4'h6};
    vecs[7]  = '{0, 3'd7, 4'h3, 4'h5, 4'h9};
    vecs[8]  = '{1, 3'd2, 4'hF, 4'hA, 4'hA};
    vecs[9]  = '{2, 3'd6, 4'hC, 4'hA, 4'h6};
    vecs[10] = '{3, 3'd5, 4'h1, 4'h2, 4'hC};

    foreach (vecs[i]) begin
      op_t[vecs[i].rid] = vecs[i].op;
      a_t[vecs[i].rid]  = vecs[i].a;
      b_t[vecs[i].rid]  = vecs[i].b;
      bus.req_valid = 4'(1 << vecs[i].rid);
      do_txn(vecs[i].rid, vecs[i].exp, 1'b1);
    end

    // Contention payloads: op=k+2, a=3k+1, b=A
    for (int k = 0; k < NREQ; k++) begin
      op_t[k] = 3'(k + 2);
      a_t[k]  = 4'(k * 3 + 1);
      b_t[k]  = 4'hA;
    end

    // Full contention: grant order 0,1,2,3,0,1,2,3
    apply_reset();
    bus.req_valid = 4'hF;
    for (int t = 0; t < 8; t++)
      do_txn(t % NREQ, ref_fn(op_t[t % NREQ], a_t[t % NREQ], b_t[t % NREQ]), 1'b0);
    bus.req_valid = '0;

    // Sparse wrap: grant 1 (ptr->2), then {0,3} -> 3 first, then 0
    apply_reset();
    bus.req_valid = 4'b0010;
    do_txn(1, ref_fn(op_t[1], a_t[1], b_t[1]), 1'b1);
    bus.req_valid = 4'b1001;
    do_txn(3, ref_fn(op_t[3], a_t[3], b_t[3]), 1'b1);
    do_txn(0, ref_fn(op_t[0], a_t[0], b_t[0]), 1'b1);

    // Back-pressure: RESP held 5 cycles while requester 2 waits
    apply_reset();
    bus.req_valid = 4'b0001;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_exec_ready", 32'(bus.req_ready), 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_data", 32'(bus.rsp_data), 32'(ref_fn(op_t[0], a_t[0], b_t[0])));
      check("bp_rsp_id", 32'(bus.rsp_id), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_busy", 32'(bus.busy), 1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_accept_valid", 32'(bus.rsp_valid), 1);
    check("bp_accept_ready", 32'(bus.req_ready), 0);
    tick();
    do_txn(2, ref_fn(op_t[2], a_t[2], b_t[2]), 1'b1);

    // Reset during EXEC: outputs clear at once, no response, ptr back to 0
    apply_reset();
    bus.req_valid = 4'b0100;
    do_txn(2, ref_fn(op_t[2], a_t[2], b_t[2]), 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    check("mid_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_rsp_id", 32'(bus.rsp_id), 0);
    check("mid_rst_rsp_data", 32'(bus.rsp_data), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("mid_no_rsp", 32'(bus.rsp_valid), 0);
      tick();
    end
    bus.req_valid = 4'b1100;
    do_txn(2, ref_fn(op_t[2], a_t[2], b_t[2]), 1'b1);
    do_txn(3, ref_fn(op_t[3], a_t[3], b_t[3]), 1'b1);

    // Random valid / rsp_ready patterns against a reference arbiter model
    apply_reset();
    mstate = 0;
    mptr   = 0;
    for (int c = 0; c < 1000; c++) begin
      v = 4'($urandom_range(0, 15));
      bus.req_valid = v;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (mstate == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          idx = (mptr + i) % NREQ;
          if (g < 0 && ((v >> idx) & 4'h1) != 4'h0) g = idx;
        end
      end
      expr = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("rand_ready", 32'(bus.req_ready), 32'(expr));
      check("rand_onehot", 32'($onehot0(bus.req_ready)), 1);
      check("rand_rsp_valid", 32'(bus.rsp_valid), (mstate == 2) ? 1 : 0);
      case (mstate)
        0: if (g >= 0) begin
             mstate = 1;
             mptr   = (g + 1) % NREQ;
           end
        1: mstate = 2;
        default: if (bus.rsp_ready) mstate = 0;
      endcase
      tick();
    end

    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
`default_nettype wire
